image_rom_arbiter: RTL and testbench
====================================

// Module: image_rom_arbiter
// PURPOSE
//   Shares one image_rom read port (12-bit address, registered 1-cycle read) between
//   N_REQ sprite drawers, e.g. the cat and dog draw blocks. Each clock it accepts at most
//   one address, chosen round-robin, and forwards it to the ROM. It returns the ROM pixel
//   to the winning requester, tagged with a per-requester valid strobe.
//   Sits between the draw_* blocks and image_rom in the VGA pipeline.
// PARAMETERS
//   N_REQ   2   number of requesters (2..8)
//   ADDR_W  12  ROM address width, {y[5:0], x[5:0]}
//   DATA_W  12  pixel width, {r[3:0], g[3:0], b[3:0]}
// PORTS
//   clk          in   1              system clock; all logic on posedge
//   rst          in   1              synchronous, active-high reset
//   req          in   N_REQ          req[i]=1: requester i presents a read address
//   addr         in   N_REQ*ADDR_W   addr[i*ADDR_W +: ADDR_W] = address of requester i
//   gnt          out  N_REQ          one-hot, registered; address of i taken in previous cycle
//   rvalid       out  N_REQ          one-hot, registered; rdata belongs to requester i this cycle
//   rdata        out  DATA_W         pixel data; equals rom_rgb, meaningful only when rvalid!=0
//   rom_address  out  ADDR_W         registered address to image_rom
//   rom_rgb      in   DATA_W         image_rom data output (1 clk after rom_address)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): gnt=0, rvalid=0, rom_address=0, all pipeline valids=0.
//     The round-robin pointer last is set to N_REQ-1, so requester 0 wins first.
//     In-flight reads are dropped; no rvalid is issued for any address accepted before reset.
//   - Arbitration at each posedge with rst=0: scan req from (last+1) mod N_REQ upward,
//     wrapping around. The first set bit is the winner w.
//     If req==0: no grant, last unchanged, stage-1 valid=0, rom_address holds its old value.
//     Otherwise: rom_address<=addr[w], gnt<=onehot(w), s1_id<=w, s1_v<=1, last<=w.
//   - Pipeline: stage 2 registers s2_id<=s1_id and s2_v<=s1_v. rvalid=s2_v ? onehot(s2_id) : 0.
//     rdata is driven combinationally from rom_rgb.
//   - Latency: req/addr sampled at edge T -> gnt high in cycle T..T+1 ->
//     rvalid/rdata high in cycle T+1..T+2. Fixed 2 clocks, no stall path.
//   - Handshake: requester holds req and addr stable until it sees gnt[i]=1.
//     If req[i] is still high in the gnt cycle, that is treated as a new request and
//     counts in the next arbitration.
//   - Throughput: one grant per clock. With all N_REQ requesting continuously, grants
//     rotate 0,1,..,N_REQ-1,0,... Each requester gets exactly 1 of every N_REQ cycles.
//     No requester waits more than N_REQ-1 cycles between grants.
//   - Single requester with req held high gets a grant every cycle.
//   - gnt and rvalid are each at most one-hot. Both may be high in the same cycle for
//     different or same requesters (pipelined reads).
//   - Ports addr[i] with req[i]=0 are ignored. X on them must not reach rom_address.
// TESTING (bench instantiates image_rom_arbiter + image_rom with a known .data file;
//   the expected value rom[a] comes from the bench's own $readmemh copy)
//   1. Reset, then req=01, addr0=12'h041 for 1 clk -> gnt=01 next cycle,
//      rom_address=12'h041. Cycle after that: rvalid=01, rdata=rom[12'h041].
//   2. req=11 held 6 clks, addr0=12'h000, addr1=12'hFFF -> gnt sequence 01,10,01,10,01,10.
//      rvalid follows 1 clk later, with rdata alternating rom[000]/rom[FFF].
//   3. req=10 held 4 clks, addr1 incrementing 12'h100..103 ->
//      gnt=10 every cycle, rvalid=10 with rdata=rom[100..103] in order, no bubbles.
//   4. req=11 for 1 clk after a grant to requester 0 -> requester 1 wins
//      (pointer honoured). Then req=01 -> requester 0 wins immediately.
//   5. Issue 2 back-to-back reads, then assert rst in the cycle after the first gnt ->
//      rvalid stays 0 for all following cycles. The next request after reset is
//      granted to requester 0 first.
//   6. Random req/addr over 10k clks, scoreboard per requester -> every grant yields
//      exactly one rvalid 1 clk later with the correct data. Max wait between grants
//      for a continuously requesting port is <= N_REQ-1.

Source files
------------

// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter
// Shares one registered-read image_rom port between N_REQ sprite drawers.
// At most one address is accepted per clock, picked round-robin. The ROM
// pixel is returned two clocks after the request was sampled, tagged with a
// one-hot rvalid that names the requester that owns it.
//
// Handshake: a requester raises req[i] with a stable addr[i] and holds both
// until it observes gnt[i]=1 (the cycle after its address was taken). A req[i]
// still high during its gnt cycle is a fresh request. There is no back-pressure
// on the return path: rvalid[i] is a one-cycle strobe and rdata must be taken
// in that same cycle.
module image_rom_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_rgb
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // round-robin pointer: id of the most recent winner
  logic [ID_W-1:0]   last;
  logic [N_REQ-1:0]  upper_mask;
  logic [N_REQ-1:0]  upper_req;
  logic [N_REQ-1:0]  cand;
  logic [ID_W-1:0]   win;
  logic [ADDR_W-1:0] win_addr;
  logic              any_req;

  // stage 1: address issued to the ROM this cycle
  logic              s1_v;
  logic [ID_W-1:0]   s1_id;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Winner select: lowest requester above the pointer, else lowest overall.
  // Only the winner's address is muxed, so undriven idle ports never leak.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper_mask[i] = (ID_W'(i) > last);
    end
    upper_req = req & upper_mask;
    cand      = (|upper_req) ? upper_req : req;
    any_req   = |req;
    win       = '0;
    win_addr  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win      = ID_W'(i);
        win_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Arbitration stage: capture winner address, grant and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      rom_address <= '0;
      s1_v        <= 1'b0;
      s1_id       <= '0;
      last        <= ID_W'(N_REQ - 1);
    end else if (any_req) begin
      gnt         <= onehot(win);
      rom_address <= win_addr;
      s1_v        <= 1'b1;
      s1_id       <= win;
      last        <= win;
    end else begin
      gnt         <= '0;
      s1_v        <= 1'b0;
    end
  end

  // Return stage: ROM data is valid now for the id issued one cycle earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
    end else begin
      rvalid <= s1_v ? onehot(s1_id) : '0;
    end
  end

  assign rdata = rom_rgb;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// tb_image_rom_arbiter
// Directed and random checks of image_rom_arbiter with a behavioural
// registered-read ROM whose contents are a fixed function of the address.
module tb_image_rom_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 12;
  localparam int DW   = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   rom_address;
  logic [DW-1:0]   rom_rgb;

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard queues: {gnt, rom_address} and {rvalid, rdata}
  logic [13:0] gnt_q[$];
  logic [13:0] rd_q[$];

  // reference model state
  int          m_last;
  logic [11:0] m_addr;

  image_rom_arbiter #(.N_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .addr        (addr),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rom_address (rom_address),
    .rom_rgb     (rom_rgb)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return 12'(a * 12'd29 + 12'h3C5);
  endfunction

  // behavioural image_rom: one-cycle registered read
  always @(posedge clk) rom_rgb <= rom_f(rom_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive req/addr, predict, then check everything due this cycle.
  task automatic cycle(input logic [1:0] r, input logic [11:0] a0, input logic [11:0] a1);
    int          w;
    bit          found;
    logic [1:0]  oh;
    logic [13:0] ge;
    logic [13:0] re;
    req   = r;
    addr  = {a1, a0};
    found = 1'b0;
    w     = m_last;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    if (found) begin
      oh     = 2'(1 << w);
      m_addr = (w == 1) ? a1 : a0;
      m_last = w;
      gnt_q.push_back({oh, m_addr});
      rd_q.push_back({oh, rom_f(m_addr)});
    end else begin
      gnt_q.push_back({2'b00, m_addr});
      rd_q.push_back(14'h0);
    end
    @(posedge clk);
    @(negedge clk);
    ge = gnt_q.pop_front();
    chk("gnt", 32'(gnt), 32'(ge[13:12]));
    chk("rom_address", 32'(rom_address), 32'(ge[11:0]));
    re = rd_q.pop_front();
    chk("rvalid", 32'(rvalid), 32'(re[13:12]));
    if (re[13:12] != 2'b00) chk("rdata", 32'(rdata), 32'(re[11:0]));
  endtask

  // Hold rst for one edge with the given requests present, then check reset state.
  task automatic reset_pulse(input logic [1:0] r, input logic [11:0] a0);
    rst  = 1'b1;
    req  = r;
    addr = {12'h000, a0};
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    req  = '0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rom_address", 32'(rom_address), 32'h0);
    m_last = NREQ - 1;
    m_addr = 12'h000;
    gnt_q.delete();
    rd_q.delete();
    rd_q.push_back(14'h0);
  endtask

  initial begin
    logic        pend [NREQ];
    logic [11:0] pa   [NREQ];
    int          wt   [NREQ];
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    m_last = NREQ - 1;
    m_addr = 12'h000;
    @(negedge clk);
    reset_pulse(2'b00, 12'h000);

    // single read from requester 0
    cycle(2'b01, 12'h041, 12'hxxx);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_addr", 32'(rom_address), 32'h041);
    cycle(2'b00, 12'hxxx, 12'hxxx);
    chk("t1_rdata", 32'(rdata), 32'(rom_f(12'h041)));

    // both requesting: strict alternation starting at 0
    reset_pulse(2'b00, 12'h000);
    for (int k = 0; k < 6; k++) cycle(2'b11, 12'h000, 12'hFFF);
    cycle(2'b00, 12'hxxx, 12'hxxx);

    // requester 1 alone gets a grant every cycle
    for (int k = 0; k < 4; k++) cycle(2'b10, 12'hxxx, 12'(12'h100 + k));
    cycle(2'b00, 12'hxxx, 12'hxxx);

    // pointer honoured, then lone requester 0 wins immediately
    cycle(2'b01, 12'h0A0, 12'hxxx);
    cycle(2'b11, 12'h0A1, 12'h0B1);
    cycle(2'b01, 12'h0A2, 12'hxxx);
    cycle(2'b00, 12'hxxx, 12'hxxx);
    cycle(2'b00, 12'hxxx, 12'hxxx);

    // reset in flight drops both pending reads
    cycle(2'b01, 12'h222, 12'hxxx);
    reset_pulse(2'b01, 12'h223);
    for (int k = 0; k < 3; k++) cycle(2'b00, 12'hxxx, 12'hxxx);
    cycle(2'b11, 12'h333, 12'h444);
    chk("t5_first_after_rst", 32'(gnt), 32'h1);
    cycle(2'b00, 12'hxxx, 12'hxxx);

    // random traffic with hold-until-grant requesters
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      wt[i]   = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          pa[i]   = 12'($urandom_range(0, 4095));
        end
      end
      cycle({pend[1], pend[0]}, pend[0] ? pa[0] : 12'hxxx, pend[1] ? pa[1] : 12'hxxx);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          chk("max_wait", 32'(wt[i] <= NREQ - 1), 32'h1);
          wt[i]   = 0;
          pend[i] = 1'b0;
        end else if (pend[i]) begin
          wt[i]++;
        end
      end
    end
    cycle(2'b00, 12'hxxx, 12'hxxx);
    cycle(2'b00, 12'hxxx, 12'hxxx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
